// File: rtl/pipe_sequencer_pkg.sv
// Shared definitions for pipe_sequencer: FSM state encodings, o_state width and counter sizing.
package pipe_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_BOOT     = 3'd0,
        ST_CFG_WAIT = 3'd1,
        ST_SOF_WAIT = 3'd2,
        ST_RUN      = 3'd3,
        ST_FLUSH    = 3'd4
    } state_e;

    // Bits needed to count 0..max(a,b)-1, never less than one.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/pipe_sequencer_sync_bus.sv
// sync_bus: generic WIDTH-bit, STAGES-deep flop synchroniser for quasi-static async inputs.
module sync_bus #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_q;
            if (gi == 0) begin : g_first
                always_ff @(posedge i_clk or negedge i_rstn) begin
                    if (!i_rstn) stage_q <= '0;
                    else         stage_q <= i_d;
                end
            end else begin : g_next
                always_ff @(posedge i_clk or negedge i_rstn) begin
                    if (!i_rstn) stage_q <= '0;
                    else         stage_q <= g_stage[gi-1].stage_q;
                end
            end
        end
    endgenerate

    assign o_q = g_stage[STAGES-1].stage_q;

endmodule

// File: rtl/pipe_sequencer.sv
// pipe_sequencer: camera-config boot sequencing plus frame-aligned stage enable switching with timed flush.
// Optional frame watchdog is compiled in when PIPE_SEQ_WATCHDOG_EN is defined.
module pipe_sequencer
    import pipe_sequencer_pkg::*;
#(
    parameter int N_STAGES     = 2,
    parameter int CFG_DELAY    = 1250000,
    parameter int FLUSH_CYCLES = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int FCNT_WIDTH   = 16,
    parameter int WDT_CYCLES   = 4000000
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_sof,
    input  logic                  i_cfg_done,
    input  logic [N_STAGES-1:0]   i_sw_stage,
    input  logic [N_STAGES-1:0]   i_stage_error,
    output logic                  o_cfg_start,
    output logic [N_STAGES-1:0]   o_stage_enable,
    output logic                  o_pipe_flush,
    output logic [FCNT_WIDTH-1:0] o_frame_count,
    output logic [N_STAGES-1:0]   o_error,
    output logic [STATE_W-1:0]    o_state,
    output logic                  o_wdt_trip
);

    localparam int               CNT_W      = cnt_width(CFG_DELAY, FLUSH_CYCLES);
    localparam logic [CNT_W-1:0] CFG_LAST   = CNT_W'(CFG_DELAY - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(FLUSH_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    cfg_start_q, cfg_start_d;
    logic [N_STAGES-1:0]     enable_q, enable_d;
    logic                    flush_q, flush_d;
    logic [FCNT_WIDTH-1:0]   fcount_q, fcount_d;
    logic [N_STAGES-1:0]     error_q, error_d;
    logic                    wdt_trip_q, wdt_trip_d;
    logic [N_STAGES-1:0]     sw_sync;
    logic                    frame_active;
    logic                    wdt_expire;

    sync_bus #(
        .WIDTH  (N_STAGES),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
        .i_d    (i_sw_stage),
        .o_q    (sw_sync)
    );

    assign frame_active = (state_q == ST_SOF_WAIT) || (state_q == ST_RUN) || (state_q == ST_FLUSH);

`ifdef PIPE_SEQ_WATCHDOG_EN
    localparam int WDT_W = (WDT_CYCLES < 2) ? 1 : $clog2(WDT_CYCLES);
    logic [WDT_W-1:0] wdt_cnt_q, wdt_cnt_d;

    // Counts cycles since the last SOF while frames are expected; FLUSH is exempt.
    always_comb begin
        wdt_cnt_d  = '0;
        wdt_expire = 1'b0;
        if (state_q == ST_SOF_WAIT || state_q == ST_RUN) begin
            if (i_sof)
                wdt_cnt_d = '0;
            else if (wdt_cnt_q == WDT_W'(WDT_CYCLES - 1))
                wdt_expire = 1'b1;
            else
                wdt_cnt_d = wdt_cnt_q + WDT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) wdt_cnt_q <= '0;
        else         wdt_cnt_q <= wdt_cnt_d;
    end
`else
    logic unused_wdt_cycles;
    assign unused_wdt_cycles = (WDT_CYCLES != 0);
    assign wdt_expire        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_start_d = 1'b0;
        enable_d    = enable_q;
        flush_d     = flush_q;
        fcount_d    = fcount_q;
        error_d     = error_q | i_stage_error;
        wdt_trip_d  = wdt_trip_q;

        if (frame_active && i_sof)
            fcount_d = fcount_q + FCNT_WIDTH'(1);

        case (state_q)
            ST_BOOT: begin
                if (cnt_q == CFG_LAST) begin
                    cfg_start_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_CFG_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CFG_WAIT: begin
                if (i_cfg_done) state_d = ST_SOF_WAIT;
            end
            ST_SOF_WAIT: begin
                if (i_sof) begin
                    enable_d = sw_sync;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                // New mode at a frame boundary: apply it and flush; stale errors go with the old mode.
                if (i_sof && (sw_sync != enable_q)) begin
                    enable_d = sw_sync;
                    flush_d  = 1'b1;
                    cnt_d    = '0;
                    error_d  = i_stage_error;
                    state_d  = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == FLUSH_LAST) begin
                    flush_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_SOF_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_BOOT;
                cnt_d   = '0;
            end
        endcase

        // Lost camera config or a stalled frame stream forces a full re-boot.
        if (frame_active && (!i_cfg_done || wdt_expire)) begin
            state_d    = ST_BOOT;
            cnt_d      = '0;
            enable_d   = '0;
            flush_d    = 1'b0;
            fcount_d   = '0;
            error_d    = error_q | i_stage_error;
            wdt_trip_d = wdt_trip_q | wdt_expire;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_BOOT;
            cnt_q       <= '0;
            cfg_start_q <= 1'b0;
            enable_q    <= '0;
            flush_q     <= 1'b0;
            fcount_q    <= '0;
            error_q     <= '0;
            wdt_trip_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_start_q <= cfg_start_d;
            enable_q    <= enable_d;
            flush_q     <= flush_d;
            fcount_q    <= fcount_d;
            error_q     <= error_d;
            wdt_trip_q  <= wdt_trip_d;
        end
    end

    assign o_cfg_start    = cfg_start_q;
    assign o_stage_enable = enable_q;
    assign o_pipe_flush   = flush_q;
    assign o_frame_count  = fcount_q;
    assign o_error        = error_q;
    assign o_state        = state_q;
    assign o_wdt_trip     = wdt_trip_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: directed scenarios plus randomized traffic against a frame-level model.
module tb_pipe_sequencer;

    localparam int NS  = 2;
    localparam int CD  = 10;
    localparam int FC  = 4;
    localparam int SS  = 2;
    localparam int FW  = 4;
    localparam int WDT = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sof = 1'b0;
    logic          cfg_done = 1'b0;
    logic [NS-1:0] sw = '0;
    logic [NS-1:0] serr = '0;

    logic          o_cfg_start;
    logic [NS-1:0] o_stage_enable;
    logic          o_pipe_flush;
    logic [FW-1:0] o_frame_count;
    logic [NS-1:0] o_error;
    logic [2:0]    o_state;
    logic          o_wdt_trip;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    pipe_sequencer #(
        .N_STAGES     (NS),
        .CFG_DELAY    (CD),
        .FLUSH_CYCLES (FC),
        .SYNC_STAGES  (SS),
        .FCNT_WIDTH   (FW),
        .WDT_CYCLES   (WDT)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rst_n),
        .i_sof          (sof),
        .i_cfg_done     (cfg_done),
        .i_sw_stage     (sw),
        .i_stage_error  (serr),
        .o_cfg_start    (o_cfg_start),
        .o_stage_enable (o_stage_enable),
        .o_pipe_flush   (o_pipe_flush),
        .o_frame_count  (o_frame_count),
        .o_error        (o_error),
        .o_state        (o_state),
        .o_wdt_trip     (o_wdt_trip)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: phase 0 boot, 1 config wait, 2 await frame, 3 running, 4 flushing.
    int          m_phase = 0;
    int          m_boot_cycles = 0;
    int          m_flush_left = 0;
    int          m_idle = 0;
    int          m_fc = 0;
    bit [NS-1:0] m_en = '0;
    bit [NS-1:0] m_err = '0;
    bit          m_start = 1'b0;
    bit          m_flush = 1'b0;
    bit          m_trip = 1'b0;
    bit [NS-1:0] hist [SS];
    bit [NS-1:0] sync_now;
    bit          bite;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_boot_cycles = 0; m_flush_left = 0; m_idle = 0; m_fc = 0;
            m_en = '0; m_err = '0; m_start = 0; m_flush = 0; m_trip = 0;
            for (int i = 0; i < SS; i++) hist[i] = '0;
        end else begin
            sync_now = hist[SS-1];
            for (int i = SS - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sw;
            m_start = 0;
            m_err   = m_err | serr;
            bite    = 0;
`ifdef PIPE_SEQ_WATCHDOG_EN
            if (m_phase == 2 || m_phase == 3) begin
                if (sof) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle == WDT) bite = 1;
                end
            end else begin
                m_idle = 0;
            end
`endif
            case (m_phase)
                0: begin
                    m_boot_cycles++;
                    if (m_boot_cycles == CD) begin
                        m_start = 1; m_phase = 1; m_boot_cycles = 0;
                    end
                end
                1: if (cfg_done) m_phase = 2;
                default: begin
                    if (!cfg_done || bite) begin
                        m_phase = 0; m_en = '0; m_flush = 0; m_fc = 0; m_boot_cycles = 0;
                        if (bite) m_trip = 1;
                    end else begin
                        if (sof) m_fc = (m_fc + 1) % (1 << FW);
                        if (m_phase == 2 && sof) begin
                            m_en = sync_now; m_phase = 3;
                        end else if (m_phase == 3 && sof && sync_now != m_en) begin
                            m_en = sync_now; m_flush = 1; m_flush_left = FC; m_phase = 4; m_err = serr;
                        end else if (m_phase == 4) begin
                            m_flush_left--;
                            if (m_flush_left == 0) begin
                                m_flush = 0; m_phase = 2;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("cfg_start",    int'(o_cfg_start),    int'(m_start));
            chk("stage_enable", int'(o_stage_enable), int'(m_en));
            chk("pipe_flush",   int'(o_pipe_flush),   int'(m_flush));
            chk("frame_count",  int'(o_frame_count),  m_fc);
            chk("error",        int'(o_error),        int'(m_err));
            chk("state",        int'(o_state),        m_phase);
            chk("wdt_trip",     int'(o_wdt_trip),     int'(m_trip));
        end
    end

    task automatic pulse_sof();
        @(negedge clk) sof = 1'b1;
        @(negedge clk) sof = 1'b0;
    endtask

    int n_flush;
    int n_start;
    int gap;
    int low_left;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            chk("cfg_start_edge", int'(o_cfg_start), (k == CD) ? 1 : 0);
        end

        cfg_done = 1'b1;
        sw = 2'b01;
        repeat (5) @(negedge clk);
        pulse_sof();
        chk("first_en",    int'(o_stage_enable), 1);
        chk("first_fc",    int'(o_frame_count),  1);
        chk("first_flush", int'(o_pipe_flush),   0);
        chk("first_state", int'(o_state),        3);

        @(negedge clk) serr = 2'b10;
        @(negedge clk) serr = 2'b00;
        chk("err_set", int'(o_error), 2);
        repeat (3) @(negedge clk);
        chk("err_held", int'(o_error), 2);

        sw = 2'b10;
        repeat (4) @(negedge clk);
        sw = 2'b01;
        repeat (4) @(negedge clk);
        pulse_sof();
        chk("toggle_flush", int'(o_pipe_flush),   0);
        chk("toggle_en",    int'(o_stage_enable), 1);
        chk("toggle_fc",    int'(o_frame_count),  2);

        sw = 2'b11;
        repeat (4) @(negedge clk);
        pulse_sof();
        chk("mode_en",    int'(o_stage_enable), 3);
        chk("mode_flush", int'(o_pipe_flush),   1);
        chk("mode_state", int'(o_state),        4);
        chk("mode_err",   int'(o_error),        0);
        n_flush = 1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            n_flush += int'(o_pipe_flush);
        end
        chk("flush_len",   n_flush,       FC);
        chk("after_flush", int'(o_state), 2);

        for (int i = 0; i < 17; i++) begin
            repeat (2) @(negedge clk);
            pulse_sof();
            chk("wrap_fc", int'(o_frame_count), (3 + i + 1) % 16);
        end

        repeat (52) @(negedge clk);
`ifdef PIPE_SEQ_WATCHDOG_EN
        chk("wdt_trip",  int'(o_wdt_trip),     1);
        chk("wdt_en",    int'(o_stage_enable), 0);
        chk("wdt_state", int'(o_state),        0);
        n_start = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            n_start += int'(o_cfg_start);
        end
        chk("wdt_restart", n_start, 1);
`else
        chk("no_wdt_trip",  int'(o_wdt_trip), 0);
        chk("no_wdt_state", int'(o_state),    3);
`endif

        gap = 5;
        low_left = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (gap == 0) begin
                sof = 1'b1;
                gap = $urandom_range(3, 14);
            end else begin
                sof = 1'b0;
                gap--;
            end
            if ($urandom_range(0, 99) < 8) sw = NS'($urandom);
            serr = ($urandom_range(0, 19) == 0) ? NS'($urandom) : '0;
            if (low_left > 0) begin
                low_left--;
                cfg_done = (low_left == 0);
            end else if ($urandom_range(0, 299) == 0) begin
                cfg_done = 1'b0;
                low_left = $urandom_range(5, 30);
            end
        end
        sof = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
